branch_predictor_bht: RTL and testbench

- Parametrised successor to the EX-stage branch resolver.
- Adds a direct-mapped branch history table (BHT) with a branch target buffer (BTB), using 2-bit saturating counters, for IF-stage prediction.
- Resolves RV32I conditional branches (opcode 7'b1100011) in EX, compares each outcome with the carried prediction, and raises flush/redirect on mispredict.
- Sits between fetch (prediction read) and EX (resolution and table update).

---
 rtl/branch_predictor_bht.sv | 224 ++++++++++++++++++++++
 tb/tb_branch_predictor_bht.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
// Direct-mapped branch history table with a branch target buffer, built from
// 2-bit saturating counters. Fetch reads a prediction combinationally; EX
// resolves RV32I conditional branches, raises flush/redirect on a mispredict
// and trains the table on the following clock edge.
//
// Optional build macro: BP_STATS_EN
//   defined   -> 32-bit saturating branch / mispredict counters are built
//   undefined -> stat_branches_o and stat_mispred_o are tied to zero
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | walking ptr_q over the table, clearing one valid bit per cycle
// ST_RUN  | normal prediction and table training
module branch_predictor_bht #(
    parameter int         ENTRIES   = 64,
    parameter int         XLEN      = 32,
    parameter logic [1:0] CTR_ALLOC = 2'b10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] f_pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            ex_valid_i,
    input  logic [6:0]      ex_opcode_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            br_eq_i,
    input  logic            br_lt_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output logic            flush_o,
    output logic            pcsel_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispred_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(4);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;

    // Table storage: valid bits are cleared by the INIT walk, the payload
    // arrays carry no reset since an entry is meaningless while invalid.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    // Fetch-side lookup
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    // EX-side resolution and training
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             is_cond;
    logic             actual_taken;
    logic             is_br;
    logic             mispredict;
    logic             upd_en;
    logic [1:0]       ctr_d;

    // The two low PC bits never index or tag the table.
    logic unused_fpc_lsb;
    assign unused_fpc_lsb = ^f_pc_i[1:0];

    assign busy_o = (state_q == ST_INIT);

    assign f_idx = f_pc_i[IDX_W+1:2];
    assign f_tag = f_pc_i[XLEN-1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    // Prediction is suppressed while the table is still being cleared.
    assign pred_taken_o  = !busy_o && f_hit && ctr_q[f_idx][1];
    assign pred_target_o = f_hit ? target_q[f_idx] : '0;

    // Decode the branch type and the outcome it implies from the comparators.
    always_comb begin
        is_cond      = 1'b0;
        actual_taken = 1'b0;
        case (ex_funct3_i)
            3'b000: begin
                is_cond      = 1'b1;
                actual_taken = br_eq_i;
            end
            3'b001: begin
                is_cond      = 1'b1;
                actual_taken = !br_eq_i;
            end
            3'b100, 3'b110: begin
                is_cond      = 1'b1;
                actual_taken = br_lt_i;
            end
            3'b101, 3'b111: begin
                is_cond      = 1'b1;
                actual_taken = !br_lt_i;
            end
            default: begin
                is_cond      = 1'b0;
                actual_taken = 1'b0;
            end
        endcase
    end

    assign is_br = ex_valid_i && (ex_opcode_i == OPC_BRANCH) && is_cond;

    // A taken branch predicted taken to the wrong place still needs a redirect.
    assign mispredict = is_br &&
                        ((actual_taken != ex_pred_taken_i) ||
                         (actual_taken && ex_pred_taken_i &&
                          (ex_pred_target_i != ex_target_i)));

    assign flush_o       = mispredict;
    assign pcsel_o       = mispredict;
    assign redirect_pc_o = mispredict ? (actual_taken ? ex_target_i : ex_pc_i + PC_INC)
                                      : '0;

    assign ex_idx = ex_pc_i[IDX_W+1:2];
    assign ex_tag = ex_pc_i[XLEN-1:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign upd_en = (state_q == ST_RUN) && is_br;

    // Saturating counter step for a hit entry.
    always_comb begin
        ctr_d = ctr_q[ex_idx];
        if (actual_taken) begin
            if (ctr_q[ex_idx] != 2'b11) begin
                ctr_d = ctr_q[ex_idx] + 2'b01;
            end
        end else begin
            if (ctr_q[ex_idx] != 2'b00) begin
                ctr_d = ctr_q[ex_idx] - 2'b01;
            end
        end
    end

    // Control FSM: INIT walk of the valid bits, then allocation on taken misses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    valid_q[ptr_q] <= 1'b0;
                    ptr_q          <= ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (upd_en && !ex_hit && actual_taken) begin
                        valid_q[ex_idx] <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Entry payload training: counter/target on a hit, full overwrite on a taken miss.
    always_ff @(posedge clk_i) begin
        if (!rst_i && upd_en) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_d;
                if (actual_taken) begin
                    target_q[ex_idx] <= ex_target_i;
                end
            end else if (actual_taken) begin
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target_i;
                ctr_q[ex_idx]    <= CTR_ALLOC;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    // Saturating statistics; they keep counting while the table initialises.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (is_br && (stat_br_q != 32'hFFFF_FFFF)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches_o = stat_br_q;
    assign stat_mispred_o  = stat_mp_q;
`else
    assign stat_branches_o = '0;
    assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht (ENTRIES=64, XLEN=32).
module tb_branch_predictor_bht;

    localparam int         ENTRIES = 64;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        br_eq;
    logic        br_lt;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush;
    logic        pcsel;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .ENTRIES   (ENTRIES),
        .XLEN      (32),
        .CTR_ALLOC (2'b10)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .f_pc_i           (f_pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .ex_valid_i       (ex_valid),
        .ex_opcode_i      (ex_opcode),
        .ex_funct3_i      (ex_funct3),
        .ex_pc_i          (ex_pc),
        .ex_target_i      (ex_target),
        .br_eq_i          (br_eq),
        .br_lt_i          (br_lt),
        .ex_pred_taken_i  (ex_pred_taken),
        .ex_pred_target_i (ex_pred_target),
        .flush_o          (flush),
        .pcsel_o          (pcsel),
        .redirect_pc_o    (redirect_pc),
        .busy_o           (busy),
        .stat_branches_o  (stat_branches),
        .stat_mispred_o   (stat_mispred)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_init_left = 0;
    longint unsigned m_nbr = 0;
    longint unsigned m_nmp = 0;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return (m_init_left == 0) && m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[idx_of(pc)] : 32'h0;
    endfunction

    function automatic bit m_is_br();
        return ex_valid && (ex_opcode == OPC_BR) && (ex_funct3 != 3'd2) && (ex_funct3 != 3'd3);
    endfunction

    function automatic bit m_actual();
        case (ex_funct3)
            3'd0:       return br_eq;
            3'd1:       return !br_eq;
            3'd4, 3'd6: return br_lt;
            3'd5, 3'd7: return !br_lt;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit m_misp();
        bit a;
        a = m_actual();
        return m_is_br() && ((a != ex_pred_taken) ||
                             (a && ex_pred_taken && (ex_pred_target != ex_target)));
    endfunction

    function automatic logic [31:0] m_redirect();
        if (!m_misp()) return 32'h0;
        return m_actual() ? ex_target : ex_pc + 32'd4;
    endfunction

    // Advance one clock, then update the model with the inputs that were applied.
    task automatic step();
        bit br, act, misp;
        int unsigned i;
        br   = m_is_br();
        act  = m_actual();
        misp = m_misp();
        @(posedge clk);
        if (rst) begin
            m_init_left = ENTRIES;
            m_nbr = 0;
            m_nmp = 0;
        end else begin
            if (br && m_nbr < 64'hFFFF_FFFF) m_nbr++;
            if (misp && m_nmp < 64'hFFFF_FFFF) m_nmp++;
            if (m_init_left > 0) begin
                m_init_left--;
                if (m_init_left == 0) begin
                    for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
                end
            end else if (br) begin
                i = idx_of(ex_pc);
                if (m_hit(ex_pc)) begin
                    if (act) begin
                        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = ex_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (act) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(ex_pc);
                    m_tgt[i]   = ex_target;
                    m_ctr[i]   = 2;
                end
            end
        end
        #1;
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic check_all(input string tag);
        check({tag, "_flush"},    flush,       m_misp());
        check({tag, "_pcsel"},    pcsel,       m_misp());
        check({tag, "_redirect"}, redirect_pc, m_redirect());
        check({tag, "_busy"},     busy,        m_init_left > 0);
        check({tag, "_ptaken"},   pred_taken,  m_pred_taken(f_pc));
        if (m_init_left == 0) check({tag, "_ptarget"}, pred_target, m_pred_target(f_pc));
`ifdef BP_STATS_EN
        check({tag, "_stat_br"}, stat_branches, m_nbr);
        check({tag, "_stat_mp"}, stat_mispred,  m_nmp);
`else
        check({tag, "_stat_br"}, stat_branches, 0);
        check({tag, "_stat_mp"}, stat_mispred,  0);
`endif
    endtask

    task automatic set_ex(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic beq, input logic blt,
                          input logic pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_opcode      = opc;
        ex_funct3      = f3;
        ex_pc          = pc;
        ex_target      = tgt;
        br_eq          = beq;
        br_lt          = blt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic reset_and_init(input string tag);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_ex();
        for (int k = 0; k < ENTRIES; k++) begin
            f_pc = $urandom;
            #1;
            check({tag, "_busy_hi"}, busy, 1);
            check({tag, "_ptaken_init"}, pred_taken, 0);
            step();
        end
        #1;
        check({tag, "_busy_lo"}, busy, 0);
    endtask

    typedef struct {
        logic        v;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        beq;
        logic        blt;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_flush;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] rand_pc();
        return 32'h400 + ($urandom % 6) * 4 + ($urandom % 3) * 256;
    endfunction

    task automatic random_phase(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            logic [31:0] pc, tgt;
            pc  = rand_pc();
            tgt = 32'h1000 + ($urandom % 4) * 4;
            set_ex(($urandom % 4) != 0, ($urandom % 5 == 0) ? OPC_ALU : OPC_BR,
                   3'($urandom % 8), pc, tgt, 1'($urandom), 1'($urandom), 1'b0, 32'h0);
            if ($urandom % 3 != 0) begin
                ex_pred_taken  = m_pred_taken(pc);
                ex_pred_target = m_pred_target(pc);
            end else begin
                ex_pred_taken  = 1'($urandom);
                ex_pred_target = ($urandom % 2) ? tgt : 32'h1000 + ($urandom % 4) * 4;
            end
            f_pc = rand_pc();
            #1;
            check_all(tag);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        f_pc = 32'h0;
        idle_ex();

        vecs[0]  = '{1'b1, OPC_BR,  3'd7, 32'h344,      32'h40,  1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40};
        vecs[1]  = '{1'b1, OPC_BR,  3'd4, 32'h348,      32'h500, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, OPC_BR,  3'd4, 32'h348,      32'h500, 1'b0, 1'b1, 1'b1, 32'h504, 1'b1, 32'h500};
        vecs[3]  = '{1'b1, OPC_BR,  3'd1, 32'hFFFFFFFC, 32'h20,  1'b1, 1'b0, 1'b1, 32'h20,  1'b1, 32'h0};
        vecs[4]  = '{1'b1, OPC_BR,  3'd5, 32'h34C,      32'h70,  1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        vecs[5]  = '{1'b1, OPC_BR,  3'd6, 32'h80,       32'h90,  1'b0, 1'b0, 1'b1, 32'h90,  1'b1, 32'h84};
        vecs[6]  = '{1'b1, OPC_BR,  3'd3, 32'h80,       32'h90,  1'b1, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
        vecs[7]  = '{1'b1, OPC_ALU, 3'd0, 32'h80,       32'h90,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
        vecs[8]  = '{1'b0, OPC_BR,  3'd0, 32'h80,       32'h90,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
        vecs[9]  = '{1'b1, OPC_BR,  3'd0, 32'h88,       32'h90,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
        vecs[10] = '{1'b1, OPC_BR,  3'd1, 32'h600,      32'h600, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h600};
        vecs[11] = '{1'b1, OPC_BR,  3'd7, 32'h8C,       32'h40,  1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};

        // Reset: busy for exactly ENTRIES cycles, no predictions meanwhile.
        reset_and_init("rst");
        for (int k = 0; k < 4; k++) begin
            f_pc = $urandom;
            #1;
            check("ptaken_cold", pred_taken, 0);
        end

        // Cold BEQ taken, then the allocated entry predicts taken.
        set_ex(1'b1, OPC_BR, 3'd0, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check("cold_flush", flush, 1);
        check("cold_pcsel", pcsel, 1);
        check("cold_redirect", redirect_pc, 32'h180);
        step();
        idle_ex();
        f_pc = 32'h100;
        #1;
        check("alloc_ptaken", pred_taken, 1);
        check("alloc_ptarget", pred_target, 32'h180);

        // Counter decay 10 -> 01 -> 00.
        set_ex(1'b1, OPC_BR, 3'd0, 32'h100, 32'h180, 1'b0, 1'b0, 1'b1, 32'h180);
        #1;
        check("decay1_flush", flush, 1);
        check("decay1_redirect", redirect_pc, 32'h104);
        step();
        ex_pred_taken = 1'b0;
        #1;
        check("decay2_flush", flush, 0);
        check("decay2_redirect", redirect_pc, 32'h0);
        step();
        idle_ex();
        f_pc = 32'h100;
        #1;
        check("decay_ptaken", pred_taken, 0);
        check("decay_ptarget", pred_target, 32'h180);
`ifdef BP_STATS_EN
        check("stat_branches_3", stat_branches, 3);
        check("stat_mispred_2", stat_mispred, 2);
`else
        check("stat_branches_off", stat_branches, 0);
        check("stat_mispred_off", stat_mispred, 0);
`endif
        // One taken from 00 only reaches 01: still predicts not taken.
        set_ex(1'b1, OPC_BR, 3'd0, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check_all("ctr00_taken");
        step();
        idle_ex();
        #1;
        check("ctr01_ptaken", pred_taken, 0);

        // Aliasing: same index, different tag.
        f_pc = 32'h100 + 4 * ENTRIES;
        #1;
        check("alias_miss", pred_taken, 0);
        set_ex(1'b1, OPC_BR, 3'd0, 32'h200, 32'h280, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check("alias_flush", flush, 1);
        step();
        idle_ex();
        f_pc = 32'h100;
        #1;
        check("alias_old_ptaken", pred_taken, 0);
        check("alias_old_ptarget", pred_target, 32'h0);
        f_pc = 32'h200;
        #1;
        check("alias_new_ptaken", pred_taken, 1);
        check("alias_new_ptarget", pred_target, 32'h280);

        // funct3=010 is ignored: no flush, table untouched.
        set_ex(1'b1, OPC_BR, 3'd2, 32'h200, 32'h999, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        check("f3_010_flush", flush, 0);
        check("f3_010_redirect", redirect_pc, 32'h0);
        step();
        idle_ex();
        #1;
        check("f3_010_ptaken", pred_taken, 1);
        check("f3_010_ptarget", pred_target, 32'h280);

        // Table-driven resolution vectors.
        for (int k = 0; k < 12; k++) begin
            set_ex(vecs[k].v, vecs[k].opc, vecs[k].f3, vecs[k].pc, vecs[k].tgt,
                   vecs[k].beq, vecs[k].blt, vecs[k].pt, vecs[k].ptgt);
            f_pc = vecs[k].pc;
            #1;
            check($sformatf("vec%0d_flush", k), flush, vecs[k].e_flush);
            check($sformatf("vec%0d_pcsel", k), pcsel, vecs[k].e_flush);
            check($sformatf("vec%0d_redirect", k), redirect_pc, vecs[k].e_redir);
            check_all($sformatf("vec%0d", k));
            step();
        end

        // Randomised traffic, a reset in the middle of it, then more traffic.
        random_phase(400, "rnd1");
        set_ex(1'b1, OPC_BR, 3'd0, 32'h400, 32'h1000, 1'b1, 1'b0, 1'b0, 32'h0);
        reset_and_init("midrst");
        for (int k = 0; k < 6; k++) begin
            f_pc = 32'h400 + k * 4;
            #1;
            check("midrst_cleared", pred_target, 32'h0);
        end
        random_phase(400, "rnd2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
